// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the serial ALU front end: sequencer states
// and the ALU opcode encodings used by the ALU and its benches.
package uart_alu_interface_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_CALC = 3'd3,
        S_WAIT = 3'd4
    } state_e;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_interface.sv
// Collects A, B and opcode bytes from UART RX, holds them for the ALU,
// then forwards the ALU result to UART TX with a single-cycle start pulse.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            S_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = S_CALC;
                end
            end
            // ALU inputs have been stable for a full cycle here
            S_CALC: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = (state_q == S_CALC) || (state_q == S_WAIT);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomized bench for uart_alu_interface against a transaction-level
// model, with directed transactions pinning known ALU results.
module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_res;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_done   (rx_done),
        .i_tx_done   (tx_done),
        .i_alu_result(alu_res),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                         logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return sa >>> b;
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res = alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Transaction-level model: bytes fill A, B, OP in turn while idle;
    // the opcode byte starts a one-cycle compute, then a wait for TX.
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_start, m_busy, m_calc;
    int         m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= 0; m_b <= 0; m_op <= 0; m_tx <= 0;
            m_start <= 0; m_busy <= 0; m_calc <= 0; m_idx <= 0;
        end else if (!m_busy) begin
            if (rx_done) begin
                if (m_idx == 0) m_a <= rx_data;
                if (m_idx == 1) m_b <= rx_data;
                if (m_idx == 2) begin
                    m_op   <= rx_data[5:0];
                    m_busy <= 1;
                    m_calc <= 1;
                end
                m_idx <= (m_idx == 2) ? 0 : m_idx + 1;
            end
        end else if (m_calc) begin
            m_tx    <= alu_f(m_a, m_b, m_op);
            m_start <= 1;
            m_calc  <= 0;
        end else begin
            m_start <= 0;
            if (tx_done) m_busy <= 0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_a", alu_a, m_a);
        chk("cyc_b", alu_b, m_b);
        chk("cyc_op", alu_op, m_op);
        chk("cyc_txd", tx_data, m_tx);
        chk("cyc_start", tx_start, m_start);
        chk("cyc_busy", busy, m_busy);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            tx_done = stray && ($urandom_range(0, 1) == 1);
            step();
            tx_done = 1'b0;
        end
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] opb, input logic [7:0] exp,
                       input int gap, input bit drop, input bit stray);
        logic [5:0] op6;
        op6 = opb[5:0];
        rx_byte(a);
        chk("a_load", alu_a, a);
        idle(gap, stray);
        rx_byte(b);
        chk("b_load", alu_b, b);
        idle(gap, stray);
        rx_byte(opb);
        chk("op_load", alu_op, op6);
        chk("busy_calc", busy, 1);
        chk("start_early", tx_start, 0);
        step();
        chk("start_pulse", tx_start, 1);
        chk("tx_value", tx_data, exp);
        step();
        chk("start_end", tx_start, 0);
        if (drop) begin
            rx_byte(8'h55);
            chk("drop_a", alu_a, a);
            chk("drop_busy", busy, 1);
        end
        idle($urandom_range(0, 3), 1'b0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_after", busy, 0);
        chk("tx_hold", tx_data, exp);
    endtask

    logic [5:0] ops [8];
    initial begin
        logic [7:0] a, b, o;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_SRA, OP_SRL, OP_NOR};
        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        step();
        chk("rst_a", alu_a, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();

        txn(8'h0A, 8'h05, 8'h20, 8'h0F, 1, 1'b0, 1'b0);
        txn(8'h0F, 8'h05, 8'h22, 8'h0A, 0, 1'b1, 1'b0);
        txn(8'h80, 8'h01, 8'h03, 8'hC0, 2, 1'b0, 1'b1);
        txn(8'hF0, 8'h3C, 8'hE4, 8'h30, 0, 1'b1, 1'b1);

        rx_byte(8'h11);
        rx_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", alu_a, 0);
        chk("mid_rst_b", alu_b, 0);
        chk("mid_rst_op", alu_op, 0);
        chk("mid_rst_txd", tx_data, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();
        txn(8'h03, 8'h04, 8'h20, 8'h07, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) o = 8'($urandom);
            else o = {2'($urandom), ops[$urandom_range(0, 7)]};
            idle($urandom_range(0, 2), 1'b1);
            txn(a, b, o, alu_f(a, b, o[5:0]),
                $urandom_range(0, 2), 1'($urandom), 1'($urandom));
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
